// File: rtl/screen_phase_ctrl.sv
// screen_phase_ctrl
//   Game-phase sequencer feeding the layer-priority RGB mux. It tracks the
//   title, play, hit-flash and game-over phases, counts lives, and animates
//   the game-over curtain once per frame.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   startOfFrame         one-cycle pulse per VGA frame
//   start_key            keypad level; acted on at its rising edge
//   player_hit, time_up  one-cycle game events
//   layer_en[6:0]        layer enables: player, bomb, time, tempWalls, mine,
//                        walls, background (bit 0 .. bit 6)
//   endOfGame            darken enable; the mux darkens PixelX > curtain_x
//   curtain_x[10:0]      curtain column
//   freeze               stalls player and bomb logic
//   lives[1:0]           remaining lives
//   phase[2:0]           IDLE=0 PLAY=1 FLASH=2 WIPE=3 OVER=4
module screen_phase_ctrl #(
  parameter int LIVES        = 3,
  parameter int FLASH_FRAMES = 8,
  parameter int WIPE_START   = 640,
  parameter int WIPE_END     = 86,
  parameter int WIPE_STEP    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        player_hit,
  input  logic        time_up,
  output logic [6:0]  layer_en,
  output logic        endOfGame,
  output logic [10:0] curtain_x,
  output logic        freeze,
  output logic [1:0]  lives,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    FLASH = 3'd2,
    WIPE  = 3'd3,
    OVER  = 3'd4
  } phase_t;

  phase_t      st, st_n;
  logic [1:0]  lives_n;
  logic [10:0] cx_n;
  logic [7:0]  fcnt, fcnt_n;
  logic        start_q, start_rise;
  logic [11:0] wipe_sub;
  logic        wipe_done;
  logic [6:0]  layer_en_n;
  logic        eog_n, freeze_n;

  assign start_rise = start_key & ~start_q;

  // 12-bit subtract: a step past zero shows up as bit 11 instead of wrapping
  // to a large column, so the clamp below catches it.
  assign wipe_sub  = {1'b0, curtain_x} - 12'(WIPE_STEP);
  assign wipe_done = wipe_sub[11] || (wipe_sub <= 12'(WIPE_END));

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      lives     <= 2'(LIVES);
      curtain_x <= 11'(WIPE_START);
      fcnt      <= 8'd0;
      layer_en  <= 7'h60;
      endOfGame <= 1'b0;
      freeze    <= 1'b1;
      // Track the key even in reset: a key held through reset must be
      // released and pressed again before it counts as a start. With the key
      // released this register comes out of reset as 0.
      start_q   <= start_key;
    end else begin
      st        <= st_n;
      lives     <= lives_n;
      curtain_x <= cx_n;
      fcnt      <= fcnt_n;
      layer_en  <= layer_en_n;
      endOfGame <= eog_n;
      freeze    <= freeze_n;
      start_q   <= start_key;
    end
  end

  // Next state. A frame tick seen on a transition cycle belongs to the old
  // state only; FLASH entry clears fcnt regardless of the tick.
  always_comb begin
    st_n    = st;
    lives_n = lives;
    cx_n    = curtain_x;
    fcnt_n  = fcnt;
    case (st)
      IDLE: begin
        if (start_rise) begin
          st_n    = PLAY;
          lives_n = 2'(LIVES);
          cx_n    = 11'(WIPE_START);
        end
      end
      PLAY: begin
        if (time_up) begin
          st_n = WIPE;
        end else if (player_hit) begin
          if (lives == 2'd1) begin
            lives_n = 2'd0;
            st_n    = WIPE;
          end else begin
            lives_n = lives - 2'd1;
            st_n    = FLASH;
            fcnt_n  = 8'd0;
          end
        end
      end
      FLASH: begin
        // Invulnerable here: player_hit is not looked at.
        if (time_up) begin
          st_n = WIPE;
        end else if (startOfFrame) begin
          if (fcnt == 8'(FLASH_FRAMES - 1)) st_n = PLAY;
          else                              fcnt_n = fcnt + 8'd1;
        end
      end
      WIPE: begin
        if (startOfFrame) begin
          if (wipe_done) begin
            cx_n = 11'(WIPE_END);
            st_n = OVER;
          end else begin
            cx_n = wipe_sub[10:0];
          end
        end
      end
      OVER: begin
        cx_n = 11'(WIPE_END);
        if (start_rise) begin
          st_n = IDLE;
          cx_n = 11'(WIPE_START);
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers
  // alongside it and never lag the phase by a cycle.
  always_comb begin
    layer_en_n = 7'h60;
    eog_n      = 1'b0;
    freeze_n   = 1'b1;
    case (st_n)
      IDLE: begin
        layer_en_n = 7'h60;
      end
      PLAY: begin
        layer_en_n = 7'h7F;
        freeze_n   = 1'b0;
      end
      FLASH: begin
        // Player layer blinks: two frames off, two frames on.
        layer_en_n = 7'h7E | {6'b0, fcnt_n[1]};
      end
      WIPE, OVER: begin
        layer_en_n = 7'h7F;
        eog_n      = 1'b1;
      end
      default: begin
        layer_en_n = 7'h60;
      end
    endcase
  end

  assign phase = st;

endmodule

// File: tb/tb_screen_phase_ctrl.sv
module tb_screen_phase_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        start_key = 1'b0;
  logic        player_hit = 1'b0;
  logic        time_up = 1'b0;
  logic [6:0]  layer_en;
  logic        endOfGame;
  logic [10:0] curtain_x;
  logic        freeze;
  logic [1:0]  lives;
  logic [2:0]  phase;

  screen_phase_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .start_key(start_key), .player_hit(player_hit), .time_up(time_up),
    .layer_en(layer_en), .endOfGame(endOfGame), .curtain_x(curtain_x),
    .freeze(freeze), .lives(lives), .phase(phase)
  );

  always #5 clk = ~clk;

  // Output snapshot: {phase, lives, layer_en, endOfGame, curtain_x, freeze}
  typedef struct {
    int          cyc;
    string       name;
    logic [24:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] pk(input logic [2:0] ph, input logic [1:0] lv,
                                      input logic [6:0] le, input logic eog,
                                      input int cx, input logic fz);
    return {ph, lv, le, eog, 11'(cx), fz};
  endfunction

  // Monitor: compares every expectation that targets the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [24:0] act;
      e   = q.pop_front();
      act = {phase, lives, layer_en, endOfGame, curtain_x, freeze};
      n_chk++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation (cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got ph=%0d lv=%0d le=%h eog=%b cx=%0d fz=%b, want ph=%0d lv=%0d le=%h eog=%b cx=%0d fz=%b",
                 e.name, act[24:22], act[21:20], act[19:13], act[12], act[11:1], act[0],
                 e.v[24:22], e.v[21:20], e.v[19:13], e.v[12], e.v[11:1], e.v[0]);
      end
    end
  end

  task automatic tick(input logic r, input logic sof, input logic sk,
                      input logic hit, input logic tu);
    @(negedge clk);
    reset = r; startOfFrame = sof; start_key = sk; player_hit = hit; time_up = tu;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0; player_hit = 1'b0; time_up = 1'b0;
  endtask

  task automatic chk(input string name, input logic [24:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.v = v;
    q.push_back(e);
  endtask

  // Press start: release then press, expectation after the pressing edge.
  task automatic press_start();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
  endtask

  logic [6:0] flash_le [1:7];

  initial begin
    flash_le[1] = 7'h7E; flash_le[2] = 7'h7F; flash_le[3] = 7'h7F; flash_le[4] = 7'h7E;
    flash_le[5] = 7'h7E; flash_le[6] = 7'h7F; flash_le[7] = 7'h7F;

    // Reset with start held: no start after release of reset.
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    chk("reset", pk(0, 3, 7'h60, 0, 640, 1));
    tick(0, 0, 1, 0, 0);
    chk("held_key", pk(0, 3, 7'h60, 0, 640, 1));
    tick(0, 0, 1, 1, 1);
    chk("idle_ignores", pk(0, 3, 7'h60, 0, 640, 1));

    press_start();
    chk("start", pk(1, 3, 7'h7F, 0, 640, 0));
    tick(0, 0, 0, 0, 0);

    // First hit with a coincident frame tick (not counted by FLASH).
    tick(0, 1, 0, 1, 0);
    chk("hit1", pk(2, 2, 7'h7E, 0, 640, 1));
    for (int k = 1; k <= 7; k++) begin
      tick(0, 1, 0, 0, 0);
      chk($sformatf("flash_f%0d", k), pk(2, 2, flash_le[k], 0, 640, 1));
      if (k == 3) begin
        tick(0, 0, 1, 1, 0);  // hit and start edge ignored while flashing
        chk("flash_invuln", pk(2, 2, 7'h7F, 0, 640, 1));
        tick(0, 0, 0, 0, 0);
      end
    end
    tick(0, 1, 0, 0, 0);
    chk("flash_exit", pk(1, 2, 7'h7F, 0, 640, 0));

    tick(0, 0, 0, 1, 0);
    chk("hit2", pk(2, 1, 7'h7E, 0, 640, 1));
    for (int k = 1; k <= 8; k++) tick(0, 1, 0, 0, 0);
    chk("flash2_exit", pk(1, 1, 7'h7F, 0, 640, 0));

    tick(0, 0, 0, 1, 0);
    chk("last_life", pk(3, 0, 7'h7F, 1, 640, 1));

    for (int k = 1; k <= 34; k++) begin
      tick(0, 1, 0, 0, 0);
      chk($sformatf("wipe_%0d", k), pk(3, 0, 7'h7F, 1, 640 - 16 * k, 1));
      if (k == 5) begin
        tick(0, 0, 1, 1, 1);  // all events ignored in WIPE
        chk("wipe_ignores", pk(3, 0, 7'h7F, 1, 560, 1));
        tick(0, 0, 0, 0, 0);
      end
    end
    tick(0, 1, 0, 0, 0);
    chk("wipe_clamp", pk(4, 0, 7'h7F, 1, 86, 1));
    tick(0, 1, 0, 1, 1);
    chk("over_hold", pk(4, 0, 7'h7F, 1, 86, 1));

    press_start();
    chk("over_restart", pk(0, 0, 7'h60, 0, 640, 1));
    press_start();
    chk("start2", pk(1, 3, 7'h7F, 0, 640, 0));

    tick(0, 0, 0, 1, 1);
    chk("hit_and_timeup", pk(3, 3, 7'h7F, 1, 640, 1));
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("wipe_pre_reset", pk(3, 3, 7'h7F, 1, 608, 1));
    tick(1, 1, 0, 1, 0);
    chk("reset_mid_wipe", pk(0, 3, 7'h60, 0, 640, 1));

    press_start();
    chk("start3", pk(1, 3, 7'h7F, 0, 640, 0));
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("flash_mid", pk(2, 2, 7'h7F, 0, 640, 1));
    tick(0, 1, 0, 0, 1);
    chk("timeup_in_flash", pk(3, 2, 7'h7F, 1, 640, 1));

    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
